// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback controller.
// Widths match the register-file sizing (32-bit registers, 4-bit addresses).
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    localparam int DEF_NUM_REGS = 12;
    localparam int DEF_QDEPTH   = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which source owns the write port at the coming edge.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_HEAD,
        SEL_LOAD,
        SEL_ALU
    } wb_sel_e;

endpackage

// File: rtl/wb_write_ctrl_if.sv
// Producer, register-file and forwarding signals of the writeback controller.
// The controller takes the slave side; producers/ID logic take the master side.
interface wb_write_ctrl_if #(
    parameter int NUM_REGS = wb_pkg::DEF_NUM_REGS
) ();
    import wb_pkg::*;

    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_dest;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    logic                ld_valid;
    logic [ADDR_W-1:0]   ld_dest;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_ready;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_dest;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] pend_mask;
    logic [ADDR_W-1:0]   q1_addr;
    logic [ADDR_W-1:0]   q2_addr;
    logic                q1_hit;
    logic                q2_hit;
    logic [DATA_W-1:0]   q1_data;
    logic [DATA_W-1:0]   q2_data;
    logic                bad_dest;

    modport slave (
        input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, q1_addr, q2_addr,
        output alu_ready, ld_ready, wr_en, wr_dest, wr_data, pend_mask,
               q1_hit, q2_hit, q1_data, q2_data, bad_dest
    );

    modport master (
        output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, q1_addr, q2_addr,
        input  alu_ready, ld_ready, wr_en, wr_dest, wr_data, pend_mask,
               q1_hit, q2_hit, q1_data, q2_data, bad_dest
    );
endinterface

// File: rtl/wb_res_fifo.sv
// Shift-style result FIFO: slot 0 is always the head, higher slots are younger,
// so the forwarding search can walk entries in age order without pointers.
module wb_res_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output wb_entry_t        head,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    wb_entry_t        shift_src [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_pos;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi < DEPTH - 1) begin : g_mid
                assign shift_src[gi] = mem_q[gi+1];
            end else begin : g_last
                assign shift_src[gi] = mem_q[gi];
            end
            assign entry_valid[gi] = (count_q > CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        // A pop in the same cycle frees the slot the push would otherwise land above.
        wr_pos  = pop ? (count_q - CNT_W'(1)) : count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = pop ? shift_src[i] : mem_q[i];
            if (push && (wr_pos == CNT_W'(i))) begin
                mem_d[i] = push_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign count   = count_q;
    assign head    = mem_q[0];
    assign entries = mem_q;
endmodule

// File: rtl/wb_write_ctrl.sv
// Writeback controller: merges ALU and load results into the single register-file
// write port in program order, and serves pending-state and forwarding lookups.
module wb_write_ctrl
    import wb_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int QDEPTH   = DEF_QDEPTH
) (
    input  logic           clk,
    input  logic           rst,
    wb_write_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [CNT_W-1:0]  q_count;
    wb_entry_t         q_head;
    wb_entry_t         q_entries [QDEPTH];
    logic [QDEPTH-1:0] q_valid;
    logic              q_push;
    logic              q_pop;
    logic              q_empty;
    logic              alu_ready_c;
    logic              in_range;
    wb_entry_t         alu_entry;
    wb_entry_t         ld_entry;
    wb_entry_t         sel_entry;
    wb_sel_e           sel;

    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_dest_q,  wr_dest_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              bad_dest_q, bad_dest_d;

    wb_res_fifo #(.DEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk        (clk),
        .srst       (rst),
        .push       (q_push),
        .push_entry (alu_entry),
        .pop        (q_pop),
        .count      (q_count),
        .head       (q_head),
        .entries    (q_entries),
        .entry_valid(q_valid)
    );

    always_comb begin
        alu_entry   = '{dest: bus.alu_dest, data: bus.alu_data};
        ld_entry    = '{dest: bus.ld_dest,  data: bus.ld_data};
        q_empty     = (q_count == '0);
        alu_ready_c = (q_count < CNT_W'(QDEPTH)) || ((q_count == CNT_W'(QDEPTH)) && !q_empty);

        sel       = SEL_NONE;
        sel_entry = alu_entry;
        q_push    = 1'b0;
        q_pop     = 1'b0;
        // Queued ALU results are older than any load still waiting, so they drain first.
        if (!q_empty) begin
            sel       = SEL_HEAD;
            sel_entry = q_head;
            q_pop     = 1'b1;
            q_push    = bus.alu_valid && alu_ready_c;
        end else if (bus.ld_valid) begin
            sel       = SEL_LOAD;
            sel_entry = ld_entry;
            q_push    = bus.alu_valid;
        end else if (bus.alu_valid) begin
            sel       = SEL_ALU;
            sel_entry = alu_entry;
        end

        in_range   = (int'(sel_entry.dest) < NUM_REGS);
        wr_en_d    = 1'b0;
        wr_dest_d  = wr_dest_q;
        wr_data_d  = wr_data_q;
        bad_dest_d = bad_dest_q;
        if (sel != SEL_NONE) begin
            wr_en_d   = in_range;
            wr_dest_d = sel_entry.dest;
            wr_data_d = sel_entry.data;
            if (!in_range) begin
                bad_dest_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_dest_q  <= '0;
            wr_data_q  <= '0;
            bad_dest_q <= 1'b0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_dest_q  <= wr_dest_d;
            wr_data_q  <= wr_data_d;
            bad_dest_q <= bad_dest_d;
        end
    end

    logic [NUM_REGS-1:0] pend_c;
    logic [ADDR_W-1:0]   fwd_addr [2];
    logic                fwd_hit  [2];
    logic [DATA_W-1:0]   fwd_data [2];

    assign fwd_addr[0] = bus.q1_addr;
    assign fwd_addr[1] = bus.q2_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            logic hit;
            always_comb begin
                hit = wr_en_q && (wr_dest_q == ADDR_W'(gi));
                for (int j = 0; j < QDEPTH; j++) begin
                    if (q_valid[j] && (q_entries[j].dest == ADDR_W'(gi))) begin
                        hit = 1'b1;
                    end
                end
            end
            assign pend_c[gi] = hit;
        end

        // Later queue slots are younger, so the last match in the walk wins.
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_hit[gi]  = wr_en_q && (wr_dest_q == fwd_addr[gi]);
                fwd_data[gi] = fwd_hit[gi] ? wr_data_q : '0;
                for (int j = 0; j < QDEPTH; j++) begin
                    if (q_valid[j] && (q_entries[j].dest == fwd_addr[gi])) begin
                        fwd_hit[gi]  = 1'b1;
                        fwd_data[gi] = q_entries[j].data;
                    end
                end
            end
        end
    endgenerate

    assign bus.alu_ready = alu_ready_c;
    assign bus.ld_ready  = q_empty;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_dest   = wr_dest_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.bad_dest  = bad_dest_q;
    assign bus.pend_mask = pend_c;
    assign bus.q1_hit    = fwd_hit[0];
    assign bus.q2_hit    = fwd_hit[1];
    assign bus.q1_data   = fwd_data[0];
    assign bus.q2_data   = fwd_data[1];
endmodule

// File: doc/wb_write_ctrl.md
Name: wb_write_ctrl

Overview:
- Writeback-stage controller that owns the single write port of the ID-stage register file (writeEn/dest/writeVal, sampled by the register file on the falling clock edge).
- Accepts results from two producers: the ALU path (one result per cycle, no backpressure tolerance beyond a small queue) and the load path (valid/ready handshake).
- Serialises both streams into at most one register write per cycle, in program order.
- Exposes per-register pending state and a two-port forwarding lookup for the hazard/forwarding logic in ID.

Parameters:
- DATA_W, 32, register width; matches REG_FILE_SIZE.
- ADDR_W, 4, register address width; matches REG_FILE_ADDR_LEN.
- NUM_REGS, 12, number of architectural registers.
- QDEPTH, 2, ALU result queue depth; must be 2 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result value.
- alu_ready  out  1  queue can accept an ALU result this cycle.
- ld_valid  in  1  load result present this cycle.
- ld_dest  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load result value.
- ld_ready  out  1  load result accepted this cycle.
- wr_en  out  1  to register file writeEn.
- wr_dest  out  ADDR_W  to register file dest.
- wr_data  out  DATA_W  to register file writeVal.
- pend_mask  out  NUM_REGS  bit r set: a write to register r is queued or in the output register.
- q1_addr, q2_addr  in  ADDR_W  forwarding query addresses.
- q1_hit, q2_hit  out  1  a pending write exists for the queried address.
- q1_data, q2_data  out  DATA_W  youngest pending value for the queried address; 0 when there is no hit.
- bad_dest  out  1  sticky flag: an accepted write had dest >= NUM_REGS.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Queue emptied; wr_en=0, wr_dest=0, wr_data=0.
  - pend_mask=0, bad_dest=0.
  - Any in-flight ALU or load result is discarded and not written.
- Output register:
  - wr_en/wr_dest/wr_data are registered.
  - A result accepted at edge N is on the write port during cycle N+1 and is committed by the register file at the falling edge of that cycle. Latency = 1 cycle.
- ALU queue:
  - FIFO of QDEPTH entries {dest, data}.
  - alu_ready = (count < QDEPTH) OR (count == QDEPTH AND the queue head is selected this cycle). alu_ready is combinational.
  - alu_valid while alu_ready=0 is a protocol error; the result is dropped and is not counted.
- Arbitration, one write per cycle, evaluated per rising edge:
  - If the queue is non-empty: the queue head is written; ld_ready=0; a new ALU result may still enqueue.
  - If the queue is empty and ld_valid=1: the load is written with ld_ready=1. A simultaneous alu_valid enqueues, because the load is the older instruction.
  - If the queue is empty, ld_valid=0 and alu_valid=1: the ALU result bypasses the queue straight to the output register (count stays 0).
  - If nothing is selected: wr_en=0 next cycle; wr_dest/wr_data hold their last values.
- ld_ready:
  - Combinational: asserted only when the queue is empty.
  - The load producer holds ld_valid/ld_dest/ld_data stable until it sees ld_ready=1.
- Destination range:
  - A selected result with dest >= NUM_REGS is converted to wr_en=0 and sets bad_dest.
  - That result still consumes its slot and its handshake.
- pend_mask:
  - Combinational OR over valid queue entries and the output register while wr_en=1.
  - A register written at the negedge of cycle N+1 clears from pend_mask at edge N+2.
- Forwarding lookup:
  - Priority youngest first: queue tail down to queue head, then the output register.
  - Lookup is combinational on q*_addr.
  - Results that are only arriving this cycle (inputs not yet registered) are not visible.
- Same destination in consecutive writes: both writes are issued in order; the register file ends with the younger value.

Decomposition:
- Shared package wb_pkg:
  - wb_entry_t struct {dest[ADDR_W], data[DATA_W]}.
  - Default widths tied to the global defines.
- One natural sub-module: wb_res_fifo, a parameterised QDEPTH FIFO of wb_entry_t.
  - Exposes count, head, and all entries with their valid bits for the forwarding search.
  - Synchronous active-high reset.

Test Plan:
- Reset mid-stream: queue holds 2 entries (dest 3 and dest 5), rst pulsed for 1 cycle -> wr_en=0, pend_mask=0, alu_ready=1, ld_ready=1; registers 3 and 5 are never written.
- ALU back-to-back: alu_valid for 4 cycles (dest 1..4, data 0x11..0x44), no loads -> wr_en=1 for 4 consecutive cycles starting 1 cycle later; dest/data in order; queue never used.
- Load/ALU collision: ld_valid dest 2 = 0xAAAA together with alu_valid dest 2 = 0xBBBB, both with an empty queue -> first write is 2 = 0xAAAA, second is 2 = 0xBBBB; final register 2 = 0xBBBB.
- Backpressure:
  - Stimulus: queue pre-filled to QDEPTH while a load is pending.
  - Required: ld_ready=0 until the queue drains; alu_ready=1 only in cycles where the head is consumed; no write lost or duplicated, checked against a scoreboard.
- Forwarding: pending writes 7 = 0x1 (output register) and 7 = 0x2 (queue), q1_addr=7 -> q1_hit=1, q1_data=0x2; q2_addr=8 -> q2_hit=0, q2_data=0.
- Bad destination: ALU dest 13 = 0xDEAD -> wr_en stays 0 for that slot; bad_dest=1 and stays set until rst.
